psum_drain: RTL and testbench
=============================

# psum_drain

Output drain for the systolic MAC array. Each column's bottom PE emits its accumulated partial sum one cycle after its left neighbour, so results leave the array diagonally skewed. This block de-skews the columns back into aligned rows and buffers them in a row FIFO. It presents each row on a valid/ready stream to the output-feature-map writer. It is the consumer of the psum chain, the counterpart of the PEs that produce it.

## Interface
- OFMAP_BITWIDTH, 32, width of one partial sum (matches PE psum width)
- N_COLS, 4, number of array columns (≥2)
- DEPTH, 4, row FIFO depth in rows (power of two, ≥2)
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- row_valid_in  in  1  high in the cycle column 0 presents a row's result
- psum_in  in  N_COLS*OFMAP_BITWIDTH  bottom-of-array psums; column c at bits [c*W +: W], W=OFMAP_BITWIDTH
- out_valid  out  1  a row is at the FIFO head
- out_ready  in  1  downstream accepts the head row
- out_data  out  N_COLS*OFMAP_BITWIDTH  aligned row, column 0 in LSBs
- fifo_level  out  $clog2(DEPTH+1)  rows currently stored
- overflow  out  1  sticky; a row was dropped because the FIFO was full
- row_count  out  16  rows popped since reset, wraps 0xFFFF→0

## Operation
- The array cannot be stalled, so there is no backpressure toward it. `row_valid_in` may be high every cycle, giving one row per cycle.
- Skew rule: for a row flagged at cycle T, column c's psum is valid on `psum_in` at cycle T+c.
- De-skew: column c passes through an (N_COLS-1-c)-stage register delay. Column N_COLS-1 is not delayed.
- `row_valid_in` travels down an (N_COLS-1)-stage valid shift chain. The last stage (`row_ready_int`) marks the cycle the complete row is aligned.
- Push: when `row_ready_int`=1 and the FIFO is not full, or it is full and a pop happens in the same cycle, the aligned row is written at wr_ptr.
- Drop: when `row_ready_int`=1, the FIFO is full and no pop happens, the row is discarded and `overflow` is set to 1. `overflow` stays set until `rst`.
- Pop: a pop occurs when `out_valid` && `out_ready`. It advances rd_ptr and increments `row_count`.
- `out_data` is the head entry, forced to all-zero when `out_valid`=0.
- Pointers are log2(DEPTH) bits plus a wrap bit. Full means equal indices with different wrap bits. Empty means the pointers are equal.
- `fifo_level` changes by +1 on push only, -1 on pop only, and 0 when both or neither occur.
- Psums are treated as signed two's complement and stored unmodified, except as described under Configuration.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `fifo_level`=0, `overflow`=0, `row_count`=0. All valid-chain stages and both pointers are 0. Data delay registers are not reset.
- Latency: a row flagged at T is written at the end of cycle T+N_COLS-1. `out_valid`=1 from cycle T+N_COLS if the FIFO was empty.
- Throughput: one row per cycle in and out when `out_ready`=1.
- A push into an empty FIFO is not visible in the same cycle; there is no bypass.
- `out_valid` is high at least until the cycle a pop occurs. The head data is stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-operation: `rst` in cycle R clears all state at that edge, so every in-flight or buffered row is lost. `row_valid_in` sampled during `rst`=1 is ignored. Rows flagged from R+1 onward behave normally.
- Simultaneous push and pop while full: both occur, `fifo_level` stays at DEPTH, and `overflow` is not set.

## Configuration
- `PSUM_DRAIN_RELU_EN` defined: each column value passes through ReLU before the FIFO write. A negative value (MSB=1) becomes 0; other values are unchanged.
- Not defined: values are stored unchanged. No extra logic or latency is added in either case.

## Test plan
- Single row (N_COLS=4, DEPTH=4, `out_ready`=1):
  - Stimulus: `row_valid_in` at cycle 0; column c = 10+c at cycle c.
  - Response: `out_valid`=1 at cycle 4 only, `out_data`={13,12,11,10}, `row_count`=1.
- Fill and overflow:
  - Stimulus: `out_ready`=0; 5 back-to-back rows with values k*100+c for row k=0..4.
  - Response: `fifo_level` reaches 4; `overflow` goes to 1 at row 4's push cycle.
  - Then raise `out_ready`: rows 0..3 emerge in order, intact; row 4 is never seen.
- Push and pop at full:
  - Stimulus: FIFO holds 4 rows; `out_ready`=1 in the same cycle a 5th row aligns.
  - Response: `overflow` stays 0, `fifo_level` stays 4, all 5 rows are eventually output in order.
- Reset mid-stream:
  - Stimulus: 3 rows buffered plus 1 in the skew chain; pulse `rst` for 1 cycle.
  - Response: all outputs are at their reset values the next cycle, no stale row appears, and a new row flagged afterward arrives after 4 cycles.
- ReLU:
  - Stimulus: column values {-5, 7, 0, 0x80000000}.
  - Response with `PSUM_DRAIN_RELU_EN`: {0, 7, 0, 0}.
  - Response without: {0xFFFFFFFB, 7, 0, 0x80000000}.
- `row_count` wrap:
  - Stimulus: 65536 pops.
  - Response: `row_count` returns to 0.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain: de-skews the systolic array's bottom-row partial sums into
// aligned rows and buffers them in a row FIFO, drained over valid/ready.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   row_valid_in  column 0 presents a row this cycle
//   psum_in       skewed psums, column c at [c*W +: W]
//   out_valid     a row is at the FIFO head
//   out_ready     downstream accepts the head row
//   out_data      head row (column 0 in LSBs), zero when empty
//   fifo_level    rows stored
//   overflow      sticky: an aligned row was dropped on a full FIFO
//   row_count     rows popped since reset (wraps)
//
// Optional feature macro: PSUM_DRAIN_RELU_EN (clamp negatives to 0
// before the FIFO write). Undefined by default: values pass unchanged.
module psum_drain #(
  parameter int OFMAP_BITWIDTH = 32,
  parameter int N_COLS         = 4,
  parameter int DEPTH          = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             row_valid_in,
  input  logic [N_COLS*OFMAP_BITWIDTH-1:0] psum_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_COLS*OFMAP_BITWIDTH-1:0] out_data,
  output logic [$clog2(DEPTH+1)-1:0]       fifo_level,
  output logic                             overflow,
  output logic [15:0]                      row_count
);

  localparam int W  = OFMAP_BITWIDTH;
  localparam int RW = N_COLS * W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  // Valid chain: last stage marks the cycle a row is fully aligned.
  logic [N_COLS-2:0] vld_q;
  logic [N_COLS-2:0] vld_d;
  logic              row_ready_int;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = row_valid_in;
    for (int i = 1; i < N_COLS - 1; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign row_ready_int = vld_q[N_COLS-2];

  // Per-column delay: column c waits N_COLS-1-c cycles so every
  // column lines up with the last one.
  logic [RW-1:0] row_al;

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    localparam int D = N_COLS - 1 - c;
    logic [W-1:0] col;

    if (D == 0) begin : g_pass
      assign col = psum_in[c*W +: W];
    end else begin : g_dly
      logic [W-1:0] sr_q [D];
      always_ff @(posedge clk) begin
        sr_q[0] <= psum_in[c*W +: W];
        for (int s = 1; s < D; s++) begin
          sr_q[s] <= sr_q[s-1];
        end
      end
      assign col = sr_q[D-1];
    end

`ifdef PSUM_DRAIN_RELU_EN
    assign row_al[c*W +: W] = col[W-1] ? '0 : col;
`else
    assign row_al[c*W +: W] = col;
`endif
  end

  // Row FIFO: pointers carry an extra wrap bit.
  logic [RW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          full, empty;
  logic          push, pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                 (wr_q[AW] != rd_q[AW]);

  assign pop  = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = row_ready_int && (!full || pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop) begin
      rd_d  = rd_q + 1'b1;
      cnt_d = cnt_q + 16'd1;
    end
    if (row_ready_int && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_q[AW-1:0]] <= row_al;
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign fifo_level = LW'(wr_q - rd_q);
  assign overflow   = ovf_q;
  assign row_count  = cnt_q;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed bench for psum_drain (N_COLS=4, DEPTH=4).
// Feeds skewed rows and checks alignment, FIFO, overflow, reset, wrap.
module tb_psum_drain;

  logic         clk;
  logic         rst;
  logic         row_valid_in;
  logic [127:0] psum_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [2:0]   fifo_level;
  logic         overflow;
  logic [15:0]  row_count;

  int checks;
  int failures;

  logic         hv [4];
  logic [127:0] hd [4];

  psum_drain #(
    .OFMAP_BITWIDTH(32),
    .N_COLS(4),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_valid_in(row_valid_in),
    .psum_in(psum_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .row_count(row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mkrow(input int base);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[c*32 +: 32] = 32'(base + c);
    return r;
  endfunction

  // One cycle: column c shows the row flagged c cycles ago, else junk.
  task automatic step(input logic v, input logic [127:0] row);
    for (int i = 3; i > 0; i--) begin
      hv[i] = hv[i-1];
      hd[i] = hd[i-1];
    end
    hv[0] = v;
    hd[0] = row;
    for (int c = 0; c < 4; c++) begin
      psum_in[c*32 +: 32] = hv[c] ? hd[c][c*32 +: 32]
                                  : (32'hDEAD0000 | 32'(c));
    end
    row_valid_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0;
      hd[i] = '0;
    end
    rst = 1'b1;
    row_valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] rr;
    checks   = 0;
    failures = 0;
    out_ready = 1'b1;
    psum_in = '0;
    row_valid_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    do_reset();

    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", out_data, 128'(0));
    chk("rst_level", 128'(fifo_level), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("rst_cnt", 128'(row_count), 128'(0));

    // Single row
    step(1'b1, mkrow(10));
    step(1'b0, '0);
    step(1'b0, '0);
    chk("single_c3_valid", 128'(out_valid), 128'(0));
    step(1'b0, '0);
    chk("single_c4_valid", 128'(out_valid), 128'(1));
    rr = {32'd13, 32'd12, 32'd11, 32'd10};
    chk("single_c4_data", out_data, rr);
    step(1'b0, '0);
    chk("single_c5_valid", 128'(out_valid), 128'(0));
    chk("single_c5_data", out_data, 128'(0));
    chk("single_cnt", 128'(row_count), 128'(1));

    // Fill and overflow
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b1, mkrow(k * 100));
    chk("fill_c5_level", 128'(fifo_level), 128'(2));
    step(1'b0, '0);
    chk("fill_c6_level", 128'(fifo_level), 128'(3));
    step(1'b0, '0);
    chk("fill_c7_level", 128'(fifo_level), 128'(4));
    chk("fill_c7_ovf", 128'(overflow), 128'(0));
    step(1'b0, '0);
    chk("fill_c8_level", 128'(fifo_level), 128'(4));
    chk("fill_c8_ovf", 128'(overflow), 128'(1));
    chk("fill_hold_data", out_data, mkrow(0));
    step(1'b0, '0);
    chk("fill_stable_data", out_data, mkrow(0));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("fill_drain_data", out_data, mkrow(k * 100));
      step(1'b0, '0);
    end
    chk("fill_empty", 128'(out_valid), 128'(0));
    chk("fill_cnt", 128'(row_count), 128'(5));
    chk("fill_ovf_sticky", 128'(overflow), 128'(1));

    // Reset mid-stream: 3 buffered, 1 in the skew chain
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b1, mkrow(1000 + k));
    step(1'b0, '0);
    step(1'b0, '0);
    chk("mid_level", 128'(fifo_level), 128'(3));
    rst = 1'b1;
    step(1'b1, mkrow(2000));
    rst = 1'b0;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data", out_data, 128'(0));
    chk("mid_rst_level", 128'(fifo_level), 128'(0));
    chk("mid_rst_ovf", 128'(overflow), 128'(0));
    chk("mid_rst_cnt", 128'(row_count), 128'(0));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0);
      chk("mid_no_stale", 128'(out_valid), 128'(0));
    end
    out_ready = 1'b1;
    step(1'b1, mkrow(3000));
    step(1'b0, '0);
    step(1'b0, '0);
    chk("mid_new_c3", 128'(out_valid), 128'(0));
    step(1'b0, '0);
    chk("mid_new_c4", 128'(out_valid), 128'(1));
    chk("mid_new_data", out_data, mkrow(3000));
    step(1'b0, '0);
    chk("mid_new_cnt", 128'(row_count), 128'(1));

    // Push and pop at full
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b1, mkrow(4000 + k * 10));
    step(1'b0, '0);
    step(1'b0, '0);
    chk("pp_full", 128'(fifo_level), 128'(4));
    out_ready = 1'b1;
    chk("pp_head0", out_data, mkrow(4000));
    step(1'b0, '0);
    chk("pp_level", 128'(fifo_level), 128'(4));
    chk("pp_ovf", 128'(overflow), 128'(0));
    for (int k = 1; k < 5; k++) begin
      chk("pp_data", out_data, mkrow(4000 + k * 10));
      step(1'b0, '0);
    end
    chk("pp_empty", 128'(out_valid), 128'(0));
    chk("pp_cnt", 128'(row_count), 128'(6));

    // Sign handling
    rr = {32'h80000000, 32'd0, 32'd7, 32'hFFFFFFFB};
    step(1'b1, rr);
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("relu_valid", 128'(out_valid), 128'(1));
`ifdef PSUM_DRAIN_RELU_EN
    chk("relu_data", out_data, {32'd0, 32'd0, 32'd7, 32'd0});
`else
    chk("relu_data", out_data, rr);
`endif
    step(1'b0, '0);

    // row_count wrap after 65536 pops
    do_reset();
    for (int i = 0; i < 65536; i++) step(1'b1, mkrow(i));
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("wrap_ffff", 128'(row_count), 128'(16'hFFFF));
    step(1'b0, '0);
    chk("wrap_zero", 128'(row_count), 128'(0));
    chk("wrap_ovf", 128'(overflow), 128'(0));
    chk("wrap_level", 128'(fifo_level), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
